mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Reader side of the core's debug memory port: the core takes a debug address in and returns the addressed data memory word combinationally.
- On a start command, the block sweeps a word-aligned address range over that port and captures each returned word.
- Each word is emitted with its address on a valid/ready stream toward the testbench/host dump logic.
- Sits beside the core at top level: dbg_addr_o drives the core's debug address input, dbg_data_i is fed by the core's debug data output.

Parameters:
- READ_LAT, 1, cycles between dbg_addr_o becoming stable and dbg_data_i being sampled; legal range 1..15.
- CNT_W, 16, width of the word-count input and internal remaining-word counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request, sampled only in IDLE.
- base_addr_i  in  32  first byte address; bits [1:0] ignored and forced to 0.
- num_words_i  in  CNT_W  number of 32-bit words to dump.
- abort_i  in  1  cancel the current dump.
- dbg_addr_o  out  32  address driven to the core's debug port.
- dbg_data_i  in  32  data returned from the core's debug port.
- dump_valid_o  out  1  stream beat valid.
- dump_ready_i  in  1  stream beat accepted.
- dump_addr_o  out  32  byte address of the current beat.
- dump_data_o  out  32  data of the current beat.
- dump_last_o  out  1  high with the final beat of a dump.
- busy_o  out  1  high in ADDR and SEND.
- done_o  out  1  one-cycle pulse when a dump completes or is aborted.

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - State = IDLE.
  - dbg_addr_o, dump_addr_o and dump_data_o = 0.
  - dump_valid_o, dump_last_o, busy_o and done_o = 0.
  - Internal counters = 0.
  - Reset mid-dump discards everything with no done_o pulse.
- State machine: IDLE, ADDR, SEND, DONE.
- IDLE:
  - start_i=1 and num_words_i!=0: load addr_q = {base_addr_i[31:2],2'b00}, rem_q = num_words_i, lat_q = 0, go ADDR.
  - start_i=1 and num_words_i==0: go DONE directly; no beats are emitted.
- ADDR:
  - dbg_addr_o = addr_q, held stable for the whole state.
  - lat_q increments each cycle.
  - In the cycle where lat_q == READ_LAT-1, capture dbg_data_i into dump_data_o, copy addr_q into dump_addr_o, go SEND.
- SEND:
  - dump_valid_o = 1; dump_last_o = (rem_q == 1).
  - dump_addr_o, dump_data_o and dump_last_o are held stable until accepted.
  - On dump_valid_o & dump_ready_i:
    - If rem_q == 1: go DONE.
    - Otherwise: rem_q -= 1, addr_q += 4, lat_q = 0, go ADDR.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Timing:
  - First dump_valid_o rises READ_LAT+1 cycles after the edge that samples start_i.
  - With dump_ready_i held high, one beat is accepted every READ_LAT+1 cycles.
- Address wrap: addr_q += 4 is modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
- start_i outside IDLE is ignored. base_addr_i and num_words_i are only sampled on the accepted start.
- abort_i:
  - In ADDR or SEND: go DONE on the next edge. dump_valid_o drops even without a handshake; this is the only allowed valid withdrawal.
  - Abort has priority over a same-cycle handshake: that beat counts as not accepted.
  - In IDLE or DONE: no effect.
- dbg_addr_o keeps its last value in IDLE/DONE. Outputs are glitch-free and registered, except dump_last_o, which is decoded from registered state.

Test Plan:
- Single dump, READ_LAT=1:
  - Stimulus: base 0x100, num 4, ready always 1, memory preloaded with word[i]=0xA0+i.
  - Required: beats (0x100,0xA0), (0x104,0xA1), (0x108,0xA2), (0x10C,0xA3,last) on cycles 2,4,6,8 after start; done_o pulse on cycle 9.
- Misaligned base and zero count:
  - base 0x103, num 1 -> single beat at addr 0x100, last=1.
  - num 0 -> no valid; done_o one cycle after start.
- Backpressure:
  - Stimulus: base 0x0, num 3, ready toggled 0 for 5 cycles during beat 2.
  - Required: beat 2 addr/data/valid held constant throughout; total beats 3; no duplicates or drops.
- Wrap-around:
  - Stimulus: base 0xFFFFFFF8, num 3.
  - Required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; last on the third beat.
- Abort and restart:
  - Stimulus: num 8; abort_i during beat 3's SEND with ready=0.
  - Required: valid falls, done_o pulses, busy_o=0. A new start then runs cleanly from its new base.
- Reset and start handling:
  - rstn_i low mid-ADDR -> all outputs 0 immediately (asynchronous), no done_o.
  - start_i pulsed while busy -> ignored, and the count is unchanged.
  - Repeat the single-dump case with READ_LAT=3 -> beat period 4 cycles.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Sweeps a word-aligned address range over the core's debug memory port and
// streams each captured word, with its byte address, over a valid/ready interface.
module mem_dump_reader #(
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic             abort_i,
    output logic [31:0]      dbg_addr_o,
    input  logic [31:0]      dbg_data_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [31:0]      dump_addr_o,
    output logic [31:0]      dump_data_o,
    output logic             dump_last_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]       LAT_LAST = 4'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       lat_q, lat_d;
    logic [31:0]      dbg_addr_q, dbg_addr_d;
    logic [31:0]      dump_addr_q, dump_addr_d;
    logic [31:0]      dump_data_q, dump_data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Byte offset bits of the base are deliberately discarded.
    logic unused_base_bits;
    assign unused_base_bits = &{1'b0, base_addr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        lat_d       = lat_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_words_i != '0) begin
                        addr_d  = {base_addr_i[31:2], 2'b00};
                        rem_d   = num_words_i;
                        lat_d   = 4'd0;
                        state_d = ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ADDR: begin
                if (abort_i) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 4'd1;
                    if (lat_q == LAT_LAST) begin
                        dump_data_d = dbg_data_i;
                        dump_addr_d = addr_q;
                        state_d     = SEND;
                    end
                end
            end
            SEND: begin
                // Abort wins over a same-cycle handshake.
                if (abort_i) begin
                    state_d = DONE;
                end else if (dump_ready_i) begin
                    if (rem_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        rem_d   = rem_q - CNT_ONE;
                        addr_d  = addr_q + 32'd4;
                        lat_d   = 4'd0;
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output flops are loaded from the next state so every output stays registered.
        dbg_addr_d = (state_d == ADDR) ? addr_d : dbg_addr_q;
        valid_d    = (state_d == SEND);
        busy_d     = (state_d == ADDR) || (state_d == SEND);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            dbg_addr_q  <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            dbg_addr_q  <= dbg_addr_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dbg_addr_o   = dbg_addr_q;
    assign dump_valid_o = valid_q;
    assign dump_addr_o  = dump_addr_q;
    assign dump_data_o  = dump_data_q;
    assign dump_last_o  = (state_q == SEND) && (rem_q == CNT_ONE);
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Testbench for mem_dump_reader: table of dump cases checked through a beat
// scoreboard, plus hand sequences for timing, backpressure, abort and reset.
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start3;
    logic [31:0] base, base3;
    logic [15:0] num, num3;
    logic        abort;
    logic        ready;
    logic [31:0] dbg_addr, dbg_data, dbg_addr3, dbg_data3;
    logic        dump_valid, dump_last, busy, done;
    logic [31:0] dump_addr, dump_data;
    logic        dump_valid3, dump_last3, busy3, done3;
    logic [31:0] dump_addr3, dump_data3;

    always #5 clk = ~clk;

    // Memory image: word at byte address a holds (a>>2)+0x60, so word[i] at 0x100 is 0xA0+i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    assign dbg_data  = mem_word(dbg_addr);
    assign dbg_data3 = mem_word(dbg_addr3);

    mem_dump_reader #(.READ_LAT(1), .CNT_W(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_addr_i(base),
        .num_words_i(num), .abort_i(abort), .dbg_addr_o(dbg_addr),
        .dbg_data_i(dbg_data), .dump_valid_o(dump_valid), .dump_ready_i(ready),
        .dump_addr_o(dump_addr), .dump_data_o(dump_data), .dump_last_o(dump_last),
        .busy_o(busy), .done_o(done)
    );

    mem_dump_reader #(.READ_LAT(3), .CNT_W(16)) dut3 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start3), .base_addr_i(base3),
        .num_words_i(num3), .abort_i(abort), .dbg_addr_o(dbg_addr3),
        .dbg_data_i(dbg_data3), .dump_valid_o(dump_valid3), .dump_ready_i(ready),
        .dump_addr_o(dump_addr3), .dump_data_o(dump_data3), .dump_last_o(dump_last3),
        .busy_o(busy3), .done_o(done3)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] base;
        int          num;
        logic [31:0] first;
    } vec_t;

    beat_t exp_q[$];
    int    n_vec    = 0;
    int    n_err    = 0;
    int    acc_cnt  = 0;
    int    done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every accepted beat is popped and compared.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rstn) begin
            if (done) done_cnt++;
            if (dump_valid && ready && !abort) begin
                acc_cnt++;
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("beat_addr", dump_addr, b.addr);
                    check("beat_data", dump_data, b.data);
                    check("beat_last", 32'(dump_last), 32'(b.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] first, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr = first + 32'(4 * i);
            b.data = mem_word(b.addr);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_dump(input logic [31:0] b, input int n);
        base  = b;
        num   = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_beat(input int acc_base, input int accepted, input string name);
        for (int i = 0; i < 200 && !(dump_valid === 1'b1 && acc_cnt - acc_base == accepted); i++)
            tick();
        check({name, "_beat_reached"}, 32'(dump_valid), 32'd1);
    endtask

    vec_t vecs[5];
    beat_t b1;
    int acc0, done0;

    initial begin
        vecs[0] = '{32'h0000_0100, 4, 32'h0000_0100};
        vecs[1] = '{32'h0000_0103, 1, 32'h0000_0100};
        vecs[2] = '{32'h0000_0200, 0, 32'h0000_0200};
        vecs[3] = '{32'hFFFF_FFF8, 3, 32'hFFFF_FFF8};
        vecs[4] = '{32'h0000_3000, 5, 32'h0000_3000};

        rstn = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0; ready = 1'b1;
        base = '0; num = '0; base3 = '0; num3 = '0;
        #12;
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_dbg_addr", dbg_addr, 32'd0);
        check("rst_dump_addr", dump_addr, 32'd0);
        check("rst_dump_data", dump_data, 32'd0);
        rstn = 1'b1;
        tick();

        // Single dump with exact cycle timing: beats on cycles 2,4,6,8, done on 9.
        for (int i = 0; i < 4; i++) begin
            b1.addr = 32'h100 + 32'(4 * i);
            b1.data = 32'hA0 + 32'(i);
            b1.last = (i == 3);
            exp_q.push_back(b1);
        end
        acc0 = acc_cnt;
        start_dump(32'h100, 4);
        check("t1_busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("t1_valid_c%0d", c), 32'(dump_valid), 32'((c % 2 == 0) && (c <= 8)));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 9));
            if (c < 9) tick();
        end
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_beats", 32'(acc_cnt - acc0), 32'd4);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Table-driven dumps.
        foreach (vecs[k]) begin
            push_exp(vecs[k].first, vecs[k].num);
            acc0  = acc_cnt;
            done0 = done_cnt;
            start_dump(vecs[k].base, vecs[k].num);
            wait_done(200, $sformatf("vec%0d", k));
            tick();
            check($sformatf("vec%0d_done_pulse", k), 32'(done), 32'd0);
            check($sformatf("vec%0d_done_count", k), 32'(done_cnt - done0), 32'd1);
            check($sformatf("vec%0d_beats", k), 32'(acc_cnt - acc0), 32'(vecs[k].num));
            check($sformatf("vec%0d_queue_empty", k), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'd0);
        end

        // Backpressure: beat 2 held stable for 5 cycles with ready low.
        push_exp(32'h0, 3);
        acc0 = acc_cnt;
        start_dump(32'h0, 3);
        wait_beat(acc0, 1, "bp");
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 32'(dump_valid), 32'd1);
            check("bp_hold_addr", dump_addr, 32'h4);
            check("bp_hold_data", dump_data, mem_word(32'h4));
            tick();
        end
        ready = 1'b1;
        wait_done(200, "bp");
        tick();
        check("bp_beats", 32'(acc_cnt - acc0), 32'd3);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort during beat 3 with ready low, then a clean restart.
        push_exp(32'h400, 8);
        acc0 = acc_cnt;
        start_dump(32'h400, 8);
        wait_beat(acc0, 2, "ab");
        ready = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid_drop", 32'(dump_valid), 32'd0);
        check("ab_done", 32'(done), 32'd1);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_beats", 32'(acc_cnt - acc0), 32'd2);
        exp_q.delete();
        ready = 1'b1;
        tick();
        check("ab_done_pulse", 32'(done), 32'd0);
        push_exp(32'h900, 2);
        acc0 = acc_cnt;
        start_dump(32'h900, 2);
        wait_done(200, "ab_restart");
        tick();
        check("ab_restart_beats", 32'(acc_cnt - acc0), 32'd2);
        check("ab_restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort coinciding with a handshake: the beat is not accepted.
        acc0 = acc_cnt;
        start_dump(32'hC00, 2);
        wait_beat(acc0, 0, "abhs");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abhs_beats", 32'(acc_cnt - acc0), 32'd0);
        check("abhs_done", 32'(done), 32'd1);
        check("abhs_valid", 32'(dump_valid), 32'd0);
        tick();

        // Start while busy is ignored.
        push_exp(32'h600, 3);
        acc0  = acc_cnt;
        done0 = done_cnt;
        start_dump(32'h600, 3);
        tick();
        base  = 32'h9000;
        num   = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, "sb");
        tick();
        check("sb_beats", 32'(acc_cnt - acc0), 32'd3);
        check("sb_done_count", 32'(done_cnt - done0), 32'd1);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        check("sb_idle_valid", 32'(dump_valid), 32'd0);
        check("sb_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-ADDR.
        done0 = done_cnt;
        start_dump(32'h500, 4);
        check("rs_busy_before", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_valid", 32'(dump_valid), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_dbg_addr", dbg_addr, 32'd0);
        check("rs_dump_addr", dump_addr, 32'd0);
        check("rs_dump_data", dump_data, 32'd0);
        #20 rstn = 1'b1;
        tick();
        tick();
        check("rs_no_done", 32'(done_cnt - done0), 32'd0);
        check("rs_idle_busy", 32'(busy), 32'd0);

        // READ_LAT=3: beats every 4 cycles, done on cycle 17.
        base3  = 32'h100;
        num3   = 16'd4;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("l3_valid_c%0d", c), 32'(dump_valid3), 32'((c % 4 == 0) && (c <= 16)));
            check($sformatf("l3_done_c%0d", c), 32'(done3), 32'(c == 17));
            if ((c % 4 == 0) && (c <= 16)) begin
                check($sformatf("l3_addr_c%0d", c), dump_addr3, 32'h100 + 32'(c - 4));
                check($sformatf("l3_data_c%0d", c), dump_data3, 32'hA0 + 32'(c / 4 - 1));
                check($sformatf("l3_last_c%0d", c), 32'(dump_last3), 32'(c == 16));
            end
            if (c < 17) tick();
        end
        tick();
        check("l3_done_pulse", 32'(done3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
